// File: rtl/uart_frame_decoder.sv
// UART receive-side frame decoder: unloads bytes from the UART and assembles SOF/CMD/LEN/payload/checksum frames.
// Optional inter-byte timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
  parameter int          MAX_LEN  = 8,
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic                   rxclk,
  input  logic                   reset,
  input  logic                   rxempty,
  input  logic [7:0]             rxdata,
  output logic                   uldrxdata,
  output logic [7:0]             cmd,
  output logic [3:0]             len,
  output logic [8*MAX_LEN-1:0]   payload,
  output logic                   frame_valid,
  output logic                   err_chk,
  output logic                   err_len,
  output logic                   err_timeout,
  output logic                   busy
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_CAP} fetch_state_t;
  typedef enum logic [2:0] {HUNT, GET_CMD, GET_LEN, GET_DATA, GET_CHK} frame_state_t;

  fetch_state_t         fetch_state;
  frame_state_t         frame_state;
  logic                 byte_stb;
  logic [7:0]           rx_byte;
  logic [7:0]           cmd_sh;
  logic [3:0]           len_sh;
  logic [3:0]           idx;
  logic [7:0]           chk;
  logic [8*MAX_LEN-1:0] shadow;

  // Handshake: uldrxdata is a single-cycle unload request; the UART presents
  // the byte on rxdata one cycle after the edge that samples it, and the byte
  // is captured then. byte_stb marks rx_byte valid for exactly one cycle.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      fetch_state <= F_IDLE;
      uldrxdata   <= 1'b0;
      byte_stb    <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      byte_stb <= 1'b0;
      case (fetch_state)
        F_IDLE: begin
          if (!rxempty) begin
            uldrxdata   <= 1'b1;
            fetch_state <= F_REQ;
          end
        end
        F_REQ: begin
          uldrxdata   <= 1'b0;
          fetch_state <= F_CAP;
        end
        F_CAP: begin
          rx_byte     <= rxdata;
          byte_stb    <= 1'b1;
          fetch_state <= F_IDLE;
        end
        default: begin
          uldrxdata   <= 1'b0;
          fetch_state <= F_IDLE;
        end
      endcase
    end
  end

  assign busy = (frame_state != HUNT);

`ifdef FRAME_TIMEOUT_EN
  logic [15:0] tcnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      frame_state <= HUNT;
      cmd_sh      <= 8'h00;
      len_sh      <= 4'd0;
      idx         <= 4'd0;
      chk         <= 8'h00;
      shadow      <= '0;
      cmd         <= 8'h00;
      len         <= 4'd0;
      payload     <= '0;
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      err_timeout <= 1'b0;
      tcnt        <= 16'd0;
`endif
    end else begin
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      if (byte_stb) begin
        case (frame_state)
          HUNT: begin
            if (rx_byte == SOF_BYTE) frame_state <= GET_CMD;
          end
          GET_CMD: begin
            cmd_sh      <= rx_byte;
            chk         <= rx_byte;
            shadow      <= '0;
            frame_state <= GET_LEN;
          end
          GET_LEN: begin
            // Full 8-bit compare so oversized LEN values cannot alias after truncation.
            if (rx_byte > 8'(MAX_LEN)) begin
              err_len     <= 1'b1;
              frame_state <= HUNT;
            end else begin
              len_sh      <= rx_byte[3:0];
              chk         <= chk ^ rx_byte;
              idx         <= 4'd0;
              frame_state <= (rx_byte == 8'h00) ? GET_CHK : GET_DATA;
            end
          end
          GET_DATA: begin
            shadow[8*idx +: 8] <= rx_byte;
            chk                <= chk ^ rx_byte;
            idx                <= idx + 4'd1;
            if (idx == len_sh - 4'd1) frame_state <= GET_CHK;
          end
          GET_CHK: begin
            if (rx_byte == chk) begin
              cmd         <= cmd_sh;
              len         <= len_sh;
              payload     <= shadow;
              frame_valid <= 1'b1;
            end else begin
              err_chk <= 1'b1;
            end
            frame_state <= HUNT;
          end
          default: frame_state <= HUNT;
        endcase
      end
`ifdef FRAME_TIMEOUT_EN
      // A byte strobe in the same cycle as expiry wins; the counter restarts instead.
      err_timeout <= 1'b0;
      if (byte_stb || frame_state == HUNT) begin
        tcnt <= 16'd0;
      end else if (tcnt == TIMEOUT - 16'd1) begin
        tcnt        <= 16'd0;
        err_timeout <= 1'b1;
        frame_state <= HUNT;
      end else begin
        tcnt <= tcnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: byte-queue UART model, vector table, event scoreboard.
module tb_uart_frame_decoder;

  localparam int MAX_LEN = 8;
  localparam int PW      = 8 * MAX_LEN;
  localparam int W       = 2 + 8 + 4 + PW;
`ifdef FRAME_TIMEOUT_EN
  localparam logic [15:0] TB_TIMEOUT = 16'd100;
`else
  localparam logic [15:0] TB_TIMEOUT = 16'd50000;
`endif

  // Event kinds
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_CHK   = 2'd1;
  localparam logic [1:0] K_LEN   = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  logic          clk;
  logic          rst;
  logic          rxempty;
  logic [7:0]    rxdata;
  logic          uldrxdata;
  logic [7:0]    cmd;
  logic [3:0]    len;
  logic [PW-1:0] payload;
  logic          frame_valid, err_chk, err_len, err_timeout, busy;

  uart_frame_decoder #(
    .MAX_LEN (MAX_LEN),
    .SOF_BYTE(8'hA5),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .rxclk      (clk),
    .reset      (rst),
    .rxempty    (rxempty),
    .rxdata     (rxdata),
    .uldrxdata  (uldrxdata),
    .cmd        (cmd),
    .len        (len),
    .payload    (payload),
    .frame_valid(frame_valid),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // UART model and event scoreboard, both on the inactive edge
  logic [7:0]   uart_q[$];
  logic [W-1:0] exp_q[$];
  int           pulse_cnt = 0;
  int           ev_cnt    = 0;
  logic         uld_prev  = 1'b0;
  logic [1:0]   kind;
  logic [W-1:0] got;

  initial begin
    rxempty = 1'b1;
    rxdata  = 8'h00;
  end

  always @(negedge clk) begin
    if (uldrxdata) begin
      pulse_cnt++;
      check("uld_one_cycle", W'(uld_prev), W'(1'b0));
      if (uart_q.size() > 0) rxdata = uart_q.pop_front();
    end
    uld_prev = uldrxdata;
    rxempty  = (uart_q.size() == 0);

    if (frame_valid | err_chk | err_len | err_timeout) begin
      check("one_strobe", W'($countones({frame_valid, err_chk, err_len, err_timeout})), W'(1));
      check("busy_after_end", W'(busy), W'(1'b0));
      kind = frame_valid ? K_VALID : err_chk ? K_CHK : err_len ? K_LEN : K_TMO;
      got  = {kind, cmd, len, payload};
      if (exp_q.size() == 0) begin
        check("unexpected_event", got, '0);
      end else begin
        check("event", got, exp_q.pop_front());
      end
      ev_cnt++;
    end
  end

  // Vector table
  typedef struct {
    logic [95:0]   bytes;
    int            n;
    logic [1:0]    kind;
    logic [7:0]    cmd;
    logic [3:0]    len;
    logic [PW-1:0] pl;
  } vec_t;

  vec_t          tv[$];
  logic [7:0]    exp_cmd = 8'h00;
  logic [3:0]    exp_len = 4'd0;
  logic [PW-1:0] exp_pl  = '0;

  task automatic push_bytes(input logic [95:0] b, input int n);
    for (int k = 0; k < n; k++) uart_q.push_back(b[8*(n-1-k) +: 8]);
  endtask

  task automatic wait_event(input int start_ev, input int budget, input string name);
    int c;
    c = 0;
    while (ev_cnt == start_ev && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (ev_cnt == start_ev) check({name, "_timeout"}, W'(ev_cnt), W'(start_ev + 1));
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int c;
    c = 0;
    while (pulse_cnt < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (pulse_cnt < target) check("pulse_wait", W'(pulse_cnt), W'(target));
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int start_ev, start_p;
    start_ev = ev_cnt;
    start_p  = pulse_cnt;
    if (v.kind == K_VALID) begin
      exp_cmd = v.cmd;
      exp_len = v.len;
      exp_pl  = v.pl;
    end
    exp_q.push_back({v.kind, exp_cmd, exp_len, exp_pl});
    push_bytes(v.bytes, v.n);
    wait_event(start_ev, 400, $sformatf("vec%0d", i));
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("vec%0d_unloads", i), W'(pulse_cnt - start_p), W'(v.n));
    check($sformatf("vec%0d_outputs", i), W'({cmd, len, payload}), W'({exp_cmd, exp_len, exp_pl}));
  endtask

  initial begin
    int start_ev, start_p;

    tv.push_back('{bytes: {8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65}, n: 6,
                   kind: K_VALID, cmd: 8'h10, len: 4'd2, pl: 64'h4433});
    tv.push_back('{bytes: {8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66}, n: 6,
                   kind: K_CHK, cmd: 8'h00, len: 4'd0, pl: 64'h0});
    tv.push_back('{bytes: {8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07}, n: 6,
                   kind: K_VALID, cmd: 8'h07, len: 4'd0, pl: 64'h0});
    tv.push_back('{bytes: {8'hA5, 8'h10, 8'h09}, n: 3,
                   kind: K_LEN, cmd: 8'h00, len: 4'd0, pl: 64'h0});
    tv.push_back('{bytes: {8'hA5, 8'hA5, 8'h01, 8'h5A, 8'hFE}, n: 5,
                   kind: K_VALID, cmd: 8'hA5, len: 4'd1, pl: 64'h5A});
    tv.push_back('{bytes: {8'hA5, 8'h20, 8'h13}, n: 3,
                   kind: K_LEN, cmd: 8'h00, len: 4'd0, pl: 64'h0});
    tv.push_back('{bytes: {8'hA5, 8'h3C, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                           8'h05, 8'h06, 8'h07, 8'h08, 8'h3C}, n: 12,
                   kind: K_VALID, cmd: 8'h3C, len: 4'd8, pl: 64'h0807060504030201});
    tv.push_back('{bytes: {8'hA5, 8'h11, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCF}, n: 7,
                   kind: K_VALID, cmd: 8'h11, len: 4'd3, pl: 64'hCCBBAA});

    rst = 1'b1;
    #1;
    check("reset_outputs", W'({uldrxdata, cmd, len, payload, frame_valid, err_chk, err_len, err_timeout, busy}), '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);

    for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

    // Reset in the middle of a payload; leftover UART bytes are hunted afterwards
    push_bytes({8'hA5, 8'h10, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44}, 7);
    wait_pulses(pulse_cnt + 5, 200);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midframe_reset_outputs", W'({cmd, len, payload, frame_valid, busy}), '0);
    exp_cmd = 8'h00;
    exp_len = 4'd0;
    exp_pl  = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    start_p = pulse_cnt;
    wait_pulses(start_p + uart_q.size(), 200);
    repeat (4) @(posedge clk);
    check("leftover_no_event", W'(busy), W'(1'b0));
    run_vec('{bytes: {8'hA5, 8'h42, 8'h01, 8'h99, 8'hDA}, n: 5,
              kind: K_VALID, cmd: 8'h42, len: 4'd1, pl: 64'h99}, 100);

`ifdef FRAME_TIMEOUT_EN
    // Partial frame then silence: err_timeout roughly TIMEOUT cycles after the last byte
    start_ev = ev_cnt;
    start_p  = pulse_cnt;
    exp_q.push_back({K_TMO, exp_cmd, exp_len, exp_pl});
    push_bytes({8'hA5, 8'h10}, 2);
    wait_pulses(start_p + 2, 100);
    repeat (80) @(posedge clk);
    check("timeout_not_early", W'(ev_cnt), W'(start_ev));
    wait_event(start_ev, 100, "timeout");
    run_vec('{bytes: {8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65}, n: 6,
              kind: K_VALID, cmd: 8'h10, len: 4'd2, pl: 64'h4433}, 101);
`else
    start_ev = ev_cnt;
    start_p  = pulse_cnt;
#0;
`endif

    repeat (5) @(posedge clk);
    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
